// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes and RAM port of the unified-RAM arbiter
interface mem_arbiter_if #(parameter int ADDR_W = 8, parameter int DATA_W = 32);
  logic if_req;
  logic [ADDR_W-1:0] if_addr;
  logic if_gnt;
  logic if_done;
  logic [DATA_W-1:0] if_rdata;
  logic d_req;
  logic d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic d_gnt;
  logic d_done;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic ram_w_en;
  logic [DATA_W-1:0] ram_rdata;
  logic busy;
  logic owner;
  modport slave (
    input if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    output if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
    output ram_addr, ram_wdata, ram_w_en, busy, owner
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    input if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
    input ram_addr, ram_wdata, ram_w_en, busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter for a single-port RAM with fixed read latency
// and a starvation limit that forces fetch progress under sustained data traffic.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RAM_LAT = 1,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [3:0] LAT_LAST = 4'(RAM_LAT - 1);
  localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);
  state_t state;
  logic [3:0] lat_cnt, starve;
  logic we, owner, if_done, d_done, ram_w_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, if_rdata, d_rdata;
  logic idle, fetch_win, grant, rd_resp;
  always_comb begin
    idle = state == IDLE;
    fetch_win = bus.if_req && (!bus.d_req || starve == STARVE_TOP);
    grant = idle && (bus.if_req || bus.d_req);
    rd_resp = state == RESP && !we;
  end
  // grants are combinational so the requester sees acceptance in the request cycle
  assign bus.if_gnt = rst_n && grant && fetch_win;
  assign bus.d_gnt = rst_n && grant && !fetch_win;
  assign bus.if_done = if_done;
  assign bus.d_done = d_done;
  assign bus.if_rdata = rd_resp && !owner ? bus.ram_rdata : if_rdata;
  assign bus.d_rdata = rd_resp && owner ? bus.ram_rdata : d_rdata;
  assign bus.ram_addr = ram_addr;
  assign bus.ram_wdata = ram_wdata;
  assign bus.ram_w_en = ram_w_en;
  assign bus.busy = !idle;
  assign bus.owner = owner;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lat_cnt <= '0;
      starve <= '0;
      we <= 1'b0;
      owner <= 1'b0;
      if_done <= 1'b0;
      d_done <= 1'b0;
      ram_w_en <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      if_rdata <= '0;
      d_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          state <= ACCESS;
          lat_cnt <= '0;
          owner <= !fetch_win;
          we <= !fetch_win && bus.d_we;
          ram_w_en <= !fetch_win && bus.d_we;
          ram_addr <= fetch_win ? bus.if_addr : bus.d_addr;
          if (!fetch_win) ram_wdata <= bus.d_wdata;
          starve <= (!fetch_win && bus.if_req) ? (starve == STARVE_TOP ? starve : starve + 4'd1) : '0;
        end
        ACCESS: begin
          ram_w_en <= 1'b0;
          lat_cnt <= lat_cnt + 4'd1;
          if (lat_cnt == LAT_LAST) begin
            state <= RESP;
            if_done <= !owner;
            d_done <= owner;
          end
        end
        RESP: begin
          state <= IDLE;
          if_done <= 1'b0;
          d_done <= 1'b0;
          if (rd_resp && !owner) if_rdata <= bus.ram_rdata;
          if (rd_resp && owner) d_rdata <= bus.ram_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (RAM_LAT 1 and 3) under directed and random traffic,
// checked against a transaction-timeline model of the arbitration rules.
module tb_mem_arbiter;
  localparam int AW = 8, DW = 32, SM = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] rst_n, if_req, d_req, d_we;
  logic [AW-1:0] if_addr [2], d_addr [2];
  logic [DW-1:0] d_wdata [2];
  logic [1:0] o_if_gnt, o_if_done, o_d_gnt, o_d_done, o_w_en, o_busy, o_owner;
  logic [AW-1:0] o_addr [2];
  logic [DW-1:0] o_wdata [2], o_if_rdata [2], o_d_rdata [2];
  function automatic logic [DW-1:0] init_word(input int i);
    return i == 16 ? 32'hE3A01005 : 32'(i) * 32'h9E3779B1;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : gd
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b ();
    logic [DW-1:0] mem [256];
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(g == 0 ? 1 : 3), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst_n(rst_n[g]), .bus(b.slave));
    initial for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    always @(posedge clk) if (b.ram_w_en) mem[b.ram_addr] <= b.ram_wdata;
    assign b.if_req = if_req[g];
    assign b.if_addr = if_addr[g];
    assign b.d_req = d_req[g];
    assign b.d_we = d_we[g];
    assign b.d_addr = d_addr[g];
    assign b.d_wdata = d_wdata[g];
    assign b.ram_rdata = mem[b.ram_addr];
    assign o_if_gnt[g] = b.if_gnt;
    assign o_if_done[g] = b.if_done;
    assign o_d_gnt[g] = b.d_gnt;
    assign o_d_done[g] = b.d_done;
    assign o_w_en[g] = b.ram_w_en;
    assign o_busy[g] = b.busy;
    assign o_owner[g] = b.owner;
    assign o_addr[g] = b.ram_addr;
    assign o_wdata[g] = b.ram_wdata;
    assign o_if_rdata[g] = b.if_rdata;
    assign o_d_rdata[g] = b.d_rdata;
  end
  int lat [2] = '{1, 3};
  int cyc, n_chk, n_fail, p_if, p_d;
  bit m_act [2], m_own [2], m_we [2], got_if [2], got_d [2], rst_trig [2];
  int g_cyc [2], m_st [2], run [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wd [2], m_ird [2], m_drd [2];
  logic [DW-1:0] mdl [2][256];
  bit pf, pd, pd_we;
  logic [AW-1:0] pf_addr, pd_addr;
  logic [DW-1:0] pd_wd;
  task automatic chk(input int k, input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lat%0d cycle %0d: got %0h expected %0h", tag, lat[k], cyc, act, exp);
    end
  endtask
  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      if (got_if[k]) if_req[k] = 1'b0;
      if (got_d[k]) d_req[k] = 1'b0;
      got_if[k] = 1'b0;
      got_d[k] = 1'b0;
      if (pf) begin
        if_req[k] = 1'b1;
        if_addr[k] = pf_addr;
      end else if (!if_req[k] && $urandom_range(99) < p_if) begin
        if_req[k] = 1'b1;
        if_addr[k] = 8'($urandom_range(31));
      end
      if (pd) begin
        d_req[k] = 1'b1;
        d_we[k] = pd_we;
        d_addr[k] = pd_addr;
        d_wdata[k] = pd_wd;
      end else if (!d_req[k] && $urandom_range(99) < p_d) begin
        d_req[k] = 1'b1;
        d_we[k] = 1'($urandom_range(1));
        d_addr[k] = 8'($urandom_range(31));
        d_wdata[k] = $urandom();
      end
    end
    pf = 1'b0;
    pd = 1'b0;
  endtask
  task automatic check_cycle(input int k);
    int ph;
    bit idle, fw, e_ig, e_dg, e_idn, e_ddn, e_wen;
    logic [DW-1:0] e_ird, e_drd;
    ph = cyc - g_cyc[k];
    idle = !(m_act[k] && ph <= lat[k] + 1);
    fw = if_req[k] && (!d_req[k] || m_st[k] == SM);
    e_ig = idle && fw;
    e_dg = idle && d_req[k] && !fw;
    e_wen = !idle && ph == 1 && m_we[k];
    e_idn = !idle && ph == lat[k] + 1 && !m_own[k];
    e_ddn = !idle && ph == lat[k] + 1 && m_own[k];
    e_ird = e_idn ? mdl[k][m_addr[k]] : m_ird[k];
    e_drd = (e_ddn && !m_we[k]) ? mdl[k][m_addr[k]] : m_drd[k];
    chk(k, "if_gnt", o_if_gnt[k], e_ig);
    chk(k, "d_gnt", o_d_gnt[k], e_dg);
    chk(k, "busy", o_busy[k], !idle);
    chk(k, "ram_w_en", o_w_en[k], e_wen);
    chk(k, "if_done", o_if_done[k], e_idn);
    chk(k, "d_done", o_d_done[k], e_ddn);
    chk(k, "if_rdata", o_if_rdata[k], e_ird);
    chk(k, "d_rdata", o_d_rdata[k], e_drd);
    if (!idle) begin
      chk(k, "owner", o_owner[k], m_own[k]);
      chk(k, "ram_addr", o_addr[k], m_addr[k]);
      if (m_own[k] && m_we[k]) chk(k, "ram_wdata", o_wdata[k], m_wd[k]);
    end
    // a fetch that beats a pending data request must follow exactly SM data grants
    if (o_d_gnt[k]) run[k] = if_req[k] ? run[k] + 1 : 0;
    if (o_if_gnt[k]) begin
      if (d_req[k]) chk(k, "starve_run", run[k], SM);
      run[k] = 0;
    end
    if (e_wen) mdl[k][m_addr[k]] = m_wd[k];
    if (e_idn) m_ird[k] = e_ird;
    if (e_ddn) m_drd[k] = e_drd;
    if (e_ig || e_dg) begin
      m_act[k] = 1'b1;
      g_cyc[k] = cyc;
      m_own[k] = e_dg;
      m_we[k] = e_dg && d_we[k];
      m_addr[k] = e_dg ? d_addr[k] : if_addr[k];
      m_wd[k] = d_wdata[k];
      m_st[k] = (e_dg && if_req[k]) ? (m_st[k] == SM ? SM : m_st[k] + 1) : 0;
      got_if[k] = e_ig;
      got_d[k] = e_dg;
    end
  endtask
  task automatic step();
    bit hit [2];
    @(posedge clk);
    #1 drive();
    #1;
    for (int k = 0; k < 2; k++) begin
      hit[k] = rst_trig[k] && m_act[k] && cyc - g_cyc[k] == (k == 0 ? 1 : 2);
      if (hit[k]) rst_n[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 2; k++) if (hit[k]) begin
      chk(k, "rst_busy", o_busy[k], 0);
      chk(k, "rst_w_en", o_w_en[k], 0);
      chk(k, "rst_d_done", o_d_done[k], 0);
      chk(k, "rst_d_gnt", o_d_gnt[k], 0);
      chk(k, "rst_d_rdata", o_d_rdata[k], 0);
      chk(k, "rst_if_rdata", o_if_rdata[k], 0);
      m_act[k] = 1'b0;
      m_st[k] = 0;
      run[k] = 0;
      m_ird[k] = '0;
      m_drd[k] = '0;
      rst_n[k] = 1'b1;
      rst_trig[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 2; k++) if (!hit[k]) check_cycle(k);
    cyc++;
  endtask
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    rst_n = 2'b00;
    if_req = 2'b00;
    d_req = 2'b00;
    d_we = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if_addr[k] = '0;
      d_addr[k] = '0;
      d_wdata[k] = '0;
      m_ird[k] = '0;
      m_drd[k] = '0;
      for (int i = 0; i < 256; i++) mdl[k][i] = init_word(i);
    end
    #3;
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst0_busy", o_busy[k], 0);
      chk(k, "rst0_w_en", o_w_en[k], 0);
      chk(k, "rst0_gnt", {o_if_gnt[k], o_d_gnt[k]}, 0);
      chk(k, "rst0_done", {o_if_done[k], o_d_done[k]}, 0);
      chk(k, "rst0_owner", o_owner[k], 0);
      chk(k, "rst0_addr", o_addr[k], 0);
      chk(k, "rst0_wdata", o_wdata[k], 0);
      chk(k, "rst0_rdata", {o_if_rdata[k], o_d_rdata[k]}, 0);
    end
    #4 rst_n = 2'b11;
    pf = 1'b1; pf_addr = 8'h10;
    run_cycles(8);
    pd = 1'b1; pd_we = 1'b1; pd_addr = 8'h20; pd_wd = 32'hDEADBEEF;
    run_cycles(8);
    pd = 1'b1; pd_we = 1'b0; pd_addr = 8'h20;
    run_cycles(8);
    pf = 1'b1; pf_addr = 8'h11; pd = 1'b1; pd_we = 1'b0; pd_addr = 8'h10;
    run_cycles(14);
    p_if = 100; p_d = 100;
    run_cycles(200);
    p_if = 35; p_d = 55;
    run_cycles(600);
    p_if = 0; p_d = 0;
    run_cycles(12);
    rst_trig = '{1'b1, 1'b1};
    pd = 1'b1; pd_we = 1'b1; pd_addr = 8'h30; pd_wd = 32'h0BADF00D;
    run_cycles(8);
    pf = 1'b1; pf_addr = 8'h30;
    run_cycles(8);
    for (int k = 0; k < 2; k++) chk(k, "rst_fired", rst_trig[k], 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
